// File: rtl/pse_pkg.sv
// Shared types and helpers for the priority scan encoder.
// Optional macro PSE_POPCOUNT_EN is consumed by priority_scan_encoder.
package pse_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } pse_state_e;

   localparam int unsigned PSE_NONE_IDX = 0;

   function automatic int pse_idx_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/pse_find_first.sv
// Combinational priority finder: winning index, any-set flag and
// exactly-one-set flag for a request vector.
module pse_find_first #(
   parameter int WIDTH     = 16,
   parameter int IDX_W     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any,
   output logic             onehot_single
);

   // Later assignments win, so the scan direction selects the priority.
   always_comb begin
      idx = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end
   end

   assign any           = |vec;
   assign onehot_single = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_scan_encoder.sv
// Registered priority scan encoder: accepts a request vector and emits every
// set index in priority order. Macro PSE_POPCOUNT_EN adds the set_count port.
//
// state | meaning
// IDLE  | ready for a new vector, no beats
// EMIT  | draining pending, one beat per handshake
module priority_scan_encoder
   import pse_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int IDX_W     = pse_idx_w(WIDTH),
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_none,
   output logic             out_last,
   output logic             busy
`ifdef PSE_POPCOUNT_EN
  ,output logic [IDX_W:0]   set_count
`endif
);

   pse_state_e       state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [IDX_W-1:0] ff_idx;
   logic             ff_any;
   logic             ff_single;
   logic             emit;
   logic             beat;

   pse_find_first #(
      .WIDTH     (WIDTH),
      .IDX_W     (IDX_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_find_first (
      .vec           (pending_q),
      .idx           (ff_idx),
      .any           (ff_any),
      .onehot_single (ff_single)
   );

   assign emit      = (state_q == EMIT);
   assign in_ready  = !emit;
   assign out_valid = emit;
   assign busy      = emit;
   assign out_none  = emit && !ff_any;
   assign out_last  = emit && (ff_single || !ff_any);
   assign out_idx   = ff_any ? ff_idx : IDX_W'(PSE_NONE_IDX);
   assign beat      = emit && out_ready && !abort;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               pending_d = in_data;
               state_d   = EMIT;
            end
         end
         EMIT: begin
            if (abort) begin
               pending_d = '0;
               state_d   = IDLE;
            end else if (out_ready) begin
               pending_d = pending_q & ~(WIDTH'(1) << ff_idx);
               if (out_last) state_d = IDLE;
            end
         end
         default: begin
            pending_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

`ifdef PSE_POPCOUNT_EN
   logic [IDX_W:0] count_q, count_d;
   logic [IDX_W:0] in_pop;

   always_comb begin
      in_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         in_pop = in_pop + (IDX_W + 1)'(in_data[i]);
      end
   end

   always_comb begin
      count_d = count_q;
      if (!emit && in_valid) begin
         count_d = in_pop;
      end else if (emit && abort) begin
         count_d = '0;
      end else if (beat && ff_any) begin
         count_d = count_q - (IDX_W + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign set_count = count_q;
`endif

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Self-checking bench: MSB-first and LSB-first instances driven in lockstep,
// compared against a queue-based model of the emitted index sequence.
module tb_priority_scan_encoder;

   localparam int W  = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          abort;
   logic          out_ready;

   logic          m_in_ready, m_out_valid, m_out_none, m_out_last, m_busy_o;
   logic [IW-1:0] m_out_idx;
   logic          l_in_ready, l_out_valid, l_out_none, l_out_last, l_busy_o;
   logic [IW-1:0] l_out_idx;
`ifdef PSE_POPCOUNT_EN
   logic [IW:0]   m_set_count, l_set_count;
`endif

   int n_vec  = 0;
   int n_fail = 0;

   // reference model
   int md_q[$];
   int ld_q[$];
   bit mdl_busy = 1'b0;
   bit mdl_zero = 1'b0;

   always #5 clk = ~clk;

   priority_scan_encoder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (m_in_ready),
      .in_data   (in_data),
      .abort     (abort),
      .out_valid (m_out_valid),
      .out_ready (out_ready),
      .out_idx   (m_out_idx),
      .out_none  (m_out_none),
      .out_last  (m_out_last),
      .busy      (m_busy_o)
`ifdef PSE_POPCOUNT_EN
     ,.set_count (m_set_count)
`endif
   );

   priority_scan_encoder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (l_in_ready),
      .in_data   (in_data),
      .abort     (abort),
      .out_valid (l_out_valid),
      .out_ready (out_ready),
      .out_idx   (l_out_idx),
      .out_none  (l_out_none),
      .out_last  (l_out_last),
      .busy      (l_busy_o)
`ifdef PSE_POPCOUNT_EN
     ,.set_count (l_set_count)
`endif
   );

   task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int exp_m, exp_l, exp_last, exp_cnt;
      exp_m    = (mdl_busy && !mdl_zero) ? md_q[0] : 0;
      exp_l    = (mdl_busy && !mdl_zero) ? ld_q[0] : 0;
      exp_last = mdl_busy && (mdl_zero || md_q.size() == 1);
      exp_cnt  = (mdl_busy && !mdl_zero) ? md_q.size() : 0;
      chk("m_in_ready",  m_in_ready,  !mdl_busy);
      chk("m_out_valid", m_out_valid, mdl_busy);
      chk("m_busy",      m_busy_o,    mdl_busy);
      chk("m_out_idx",   m_out_idx,   exp_m);
      chk("m_out_none",  m_out_none,  mdl_busy && mdl_zero);
      chk("m_out_last",  m_out_last,  exp_last);
      chk("l_in_ready",  l_in_ready,  !mdl_busy);
      chk("l_out_valid", l_out_valid, mdl_busy);
      chk("l_out_idx",   l_out_idx,   exp_l);
      chk("l_out_none",  l_out_none,  mdl_busy && mdl_zero);
      chk("l_out_last",  l_out_last,  exp_last);
`ifdef PSE_POPCOUNT_EN
      chk("m_set_count", m_set_count, exp_cnt);
      chk("l_set_count", l_set_count, exp_cnt);
`endif
   endtask

   task automatic model_clear();
      md_q.delete();
      ld_q.delete();
      mdl_busy = 1'b0;
      mdl_zero = 1'b0;
   endtask

   // One clock: check current outputs, drive inputs, predict the post-edge state.
   task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic ab);
      @(negedge clk);
      check_all();
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      abort     = ab;
      if (!mdl_busy) begin
         if (iv) begin
            model_clear();
            for (int i = W - 1; i >= 0; i--) if (d[i]) md_q.push_back(i);
            for (int i = 0; i < W; i++)      if (d[i]) ld_q.push_back(i);
            mdl_zero = (md_q.size() == 0);
            mdl_busy = 1'b1;
         end
      end else if (ab) begin
         model_clear();
      end else if (ordy) begin
         if (mdl_zero) begin
            model_clear();
         end else begin
            void'(md_q.pop_front());
            void'(ld_q.pop_front());
            if (md_q.size() == 0) model_clear();
         end
      end
      @(posedge clk);
   endtask

   // mode 0: ready high, 1: ready pattern 1,0,0 repeating, 2: random ready
   task automatic drain(input int mode);
      int c;
      c = 0;
      while (mdl_busy && c < 400) begin
         case (mode)
            0:       step(1'b0, '0, 1'b1, 1'b0);
            1:       step(1'b0, '0, (c % 3) == 0, 1'b0);
            default: step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0));
         endcase
         c++;
      end
      chk("drain_bound", mdl_busy, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      abort     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // 16'h8421, ready high
      step(1'b1, 16'h8421, 1'b1, 1'b0);
      drain(0);
      step(1'b0, '0, 1'b1, 1'b0);

      // zero vector
      step(1'b1, 16'h0000, 1'b1, 1'b0);
      drain(0);
      step(1'b0, '0, 1'b1, 1'b0);

      // all ones with stalls
      step(1'b1, 16'hFFFF, 1'b0, 1'b0);
      drain(1);
      step(1'b0, '0, 1'b1, 1'b0);

      // abort with the second handshake, then a fresh vector
      step(1'b1, 16'h00F0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 16'h0001, 1'b1, 1'b0);
      drain(0);
      step(1'b0, '0, 1'b1, 1'b0);

      // in_valid during EMIT is ignored
      step(1'b1, 16'h0011, 1'b1, 1'b0);
      step(1'b1, 16'hAAAA, 1'b1, 1'b0);
      step(1'b1, 16'hAAAA, 1'b1, 1'b0);
      drain(0);

      // asynchronous reset mid-vector
      step(1'b1, 16'h0303, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_m_out_valid", m_out_valid, 0);
      chk("arst_m_in_ready",  m_in_ready,  1);
      chk("arst_l_out_valid", l_out_valid, 0);
      chk("arst_l_in_ready",  l_in_ready,  1);
      chk("arst_m_busy",      m_busy_o,    0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(1'b0, '0, 1'b1, 1'b0);

      // randomized traffic
      for (int v = 0; v < 60; v++) begin
         logic [W-1:0] d;
         d = W'($urandom);
         if (v % 7 == 0) d = '0;
         if (v % 5 == 1) d = W'(1) << $urandom_range(0, W - 1);
         step(1'b1, d, 1'($urandom_range(0, 1)), 1'b0);
         drain(2);
         step(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
      end
      step(1'b0, '0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
